quad_enc_frontend: RTL

Parametrised N-channel quadrature-encoder front end for the motor subsystem, clocked on clk200M. Each channel's raw sa/sb pins pass through a configurable-depth synchroniser and a glitch filter, then a 4x quadrature decoder. The decoder drives a signed position counter, a per-window velocity measurement and a sticky illegal-transition flag. Outputs feed the motor controllers and the debug/OLED path; this block replaces ad-hoc per-pin 3-flop synchronisers.

---
 rtl/quad_enc_frontend.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_enc_frontend.sv
// Purpose : N-channel quadrature encoder front end (sync -> glitch filter -> 4x decode -> pos/vel/err).
// Latency : pin edge first sampled at edge k reaches pos at edge k+SYNC_STAGES+FILT_LEN.
// Backpr. : none; free-running, one step per channel per cycle at most, vel_valid is a 1-cycle pulse.
//
// Ports:
//   clk200M    system clock
//   rstn       synchronous active-low reset
//   sa, sb     raw asynchronous encoder phases, one bit per channel
//   cnt_clr    per-channel position clear strobe (does not touch velocity)
//   err_clr    clears every sticky error bit (a simultaneous new error still sets)
//   pos        signed position, channel c at [c*CNT_W +: CNT_W]
//   vel        signed step count of the last completed window, same packing
//   vel_valid  1-cycle pulse when vel is updated
//   err        sticky illegal-transition flag per channel
module quad_enc_frontend #(
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 3,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 32,
    parameter int WIN_CYCLES  = 2_000_000
) (
    input  logic                    clk200M,
    input  logic                    rstn,
    input  logic [N_CH-1:0]         sa,
    input  logic [N_CH-1:0]         sb,
    input  logic [N_CH-1:0]         cnt_clr,
    input  logic                    err_clr,
    output logic [N_CH*CNT_W-1:0]   pos,
    output logic [N_CH*CNT_W-1:0]   vel,
    output logic                    vel_valid,
    output logic [N_CH-1:0]         err
);

    localparam int              WC_W    = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN_CYCLES - 1);
    localparam logic [7:0]      FC_LAST = 8'(FILT_LEN - 1);

    // ------------------------------------------------------------------
    // Synchronisers: stage 0 samples the pin, stage SYNC_STAGES-1 is used.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync_b;

    always_ff @(posedge clk200M) begin
        if (!rstn) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], sa};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], sb};
        end
    end

    // A phases occupy [N_CH-1:0], B phases [2*N_CH-1:N_CH] of every filter vector.
    logic [2*N_CH-1:0] w_s;
    assign w_s = {r_sync_b[SYNC_STAGES-1], r_sync_a[SYNC_STAGES-1]};

    // ------------------------------------------------------------------
    // Glitch filter: a new level must be seen FILT_LEN consecutive cycles.
    // fc counts consecutive cycles of disagreement and restarts on agreement.
    // ------------------------------------------------------------------
    logic [2*N_CH-1:0]       r_f;
    logic [2*N_CH-1:0][7:0]  r_fc;

    always_ff @(posedge clk200M) begin
        if (!rstn) begin
            r_f  <= '0;
            r_fc <= '0;
        end else begin
            for (int i = 0; i < 2*N_CH; i++) begin
                if (w_s[i] == r_f[i]) begin
                    r_fc[i] <= '0;
                end else if (r_fc[i] == FC_LAST) begin
                    r_f[i]  <= w_s[i];
                    r_fc[i] <= '0;
                end else begin
                    r_fc[i] <= r_fc[i] + 8'd1;
                end
            end
        end
    end

    logic [N_CH-1:0] w_fa;
    logic [N_CH-1:0] w_fb;
    assign w_fa = r_f[N_CH-1:0];
    assign w_fb = r_f[2*N_CH-1:N_CH];

    // ------------------------------------------------------------------
    // 4x decoder: previous filtered pair against current pair.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_p_a;
    logic [N_CH-1:0] r_p_b;

    always_ff @(posedge clk200M) begin
        if (!rstn) begin
            r_p_a <= '0;
            r_p_b <= '0;
        end else begin
            r_p_a <= w_fa;
            r_p_b <= w_fb;
        end
    end

    logic [N_CH-1:0][CNT_W-1:0] w_step;
    logic [N_CH-1:0]            w_ill;
    logic                       w_chg_a;
    logic                       w_chg_b;

    // For a single-bit change in the Gray sequence 00->10->11->01 the
    // direction is forward exactly when old A equals new B.
    always_comb begin
        w_step  = '0;
        w_ill   = '0;
        w_chg_a = 1'b0;
        w_chg_b = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            w_chg_a  = r_p_a[c] ^ w_fa[c];
            w_chg_b  = r_p_b[c] ^ w_fb[c];
            w_ill[c] = w_chg_a & w_chg_b;
            if (w_chg_a ^ w_chg_b) begin
                if (r_p_a[c] == w_fb[c]) begin
                    w_step[c] = CNT_W'(1);
                end else begin
                    w_step[c] = '1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Position counters; clear wins over a coincident step.
    // ------------------------------------------------------------------
    logic [N_CH-1:0][CNT_W-1:0] r_pos;

    always_ff @(posedge clk200M) begin
        if (!rstn) begin
            r_pos <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (cnt_clr[c]) begin
                    r_pos[c] <= '0;
                end else begin
                    r_pos[c] <= r_pos[c] + w_step[c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Velocity: shared window counter, per-channel accumulator. The step of
    // the last window cycle belongs to the window being closed.
    // ------------------------------------------------------------------
    logic [WC_W-1:0]            r_wc;
    logic [N_CH-1:0][CNT_W-1:0] r_acc;
    logic [N_CH-1:0][CNT_W-1:0] r_vel;
    logic                       r_vel_valid;
    logic                       w_win_end;

    assign w_win_end = (r_wc == WC_LAST);

    always_ff @(posedge clk200M) begin
        if (!rstn) begin
            r_wc        <= '0;
            r_acc       <= '0;
            r_vel       <= '0;
            r_vel_valid <= 1'b0;
        end else begin
            r_vel_valid <= w_win_end;
            if (w_win_end) begin
                r_wc <= '0;
            end else begin
                r_wc <= r_wc + WC_W'(1);
            end
            for (int c = 0; c < N_CH; c++) begin
                if (w_win_end) begin
                    r_vel[c] <= r_acc[c] + w_step[c];
                    r_acc[c] <= '0;
                end else begin
                    r_acc[c] <= r_acc[c] + w_step[c];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error: a new illegal transition overrides err_clr.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] r_err;

    always_ff @(posedge clk200M) begin
        if (!rstn) begin
            r_err <= '0;
        end else begin
            r_err <= w_ill | (r_err & {N_CH{~err_clr}});
        end
    end

    assign pos       = r_pos;
    assign vel       = r_vel;
    assign vel_valid = r_vel_valid;
    assign err       = r_err;

endmodule
